// File: rtl/ssd_scan_driver_if.sv
// Value handshake and committed-BCD bus between the processor side and the display driver.
// The master drives value_in/in_valid; the driver (slave) returns in_ready, bcd_valid and bcd_out.
interface ssd_scan_driver_if #(
  parameter int VALUE_W = 13
);
  logic [VALUE_W-1:0] value_in;
  logic               in_valid;
  logic               in_ready;
  logic               bcd_valid;
  logic [15:0]        bcd_out;

  modport master (
    output value_in, in_valid,
    input  in_ready, bcd_valid, bcd_out
  );

  modport slave (
    input  value_in, in_valid,
    output in_ready, bcd_valid, bcd_out
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 4-digit common-anode scan driver.
// Handshake: a value transfers on a rising edge where in_valid && in_ready; in_valid is ignored otherwise.
module ssd_scan_driver #(
  parameter int VALUE_W     = 13,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                clk,
  input  logic                reset,
  ssd_scan_driver_if.slave    bus,
  output logic [3:0]          Anode,
  output logic [6:0]          LED_out,
  output logic [1:0]          fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int BC_W  = $clog2(VALUE_W + 1);
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t             state;
  logic [VALUE_W-1:0] shreg;
  logic [15:0]        work;
  logic [15:0]        adj;
  logic [BC_W-1:0]    bitcnt;
  logic [15:0]        bcd_r;
  logic               bcd_valid_r;
  logic               in_ready_r;

  logic [CNT_W-1:0]   refresh_cnt;
  logic [1:0]         idx;
  logic [3:0]         digit;
  logic [15:0]        higher;
  logic               blank;

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    adj = work;
    for (int k = 0; k < 4; k++) begin
      if (work[4*k +: 4] >= 4'd5) adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shreg       <= '0;
      work        <= '0;
      bitcnt      <= '0;
      bcd_r       <= '0;
      bcd_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      bcd_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            shreg      <= bus.value_in;
            work       <= '0;
            bitcnt     <= BC_W'(VALUE_W - 1);
            in_ready_r <= 1'b0;
            state      <= CONV;
          end
        end
        CONV: begin
          work  <= {adj[14:0], shreg[VALUE_W-1]};
          shreg <= shreg << 1;
          if (bitcnt == '0) state <= COMMIT;
          else              bitcnt <= bitcnt - 1'b1;
        end
        COMMIT: begin
          bcd_r       <= work;
          bcd_valid_r <= 1'b1;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          in_ready_r <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.bcd_out   = bcd_r;
  assign bus.bcd_valid = bcd_valid_r;
  assign bus.in_ready  = in_ready_r;
  assign fsm_state     = state;

  // Free-running scan; a commit does not restart it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      idx         <= 2'd0;
    end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      idx         <= idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  always_comb begin
    digit  = bcd_r[{idx, 2'b00} +: 4];
    higher = bcd_r >> {idx, 2'b00};
    blank  = (BLANK_LZ != 0) && (idx != 2'd0) && (higher == 16'd0);

    case (idx)
      2'd0:    Anode = 4'b1110;
      2'd1:    Anode = 4'b1101;
      2'd2:    Anode = 4'b1011;
      default: Anode = 4'b0111;
    endcase

    if (blank) begin
      LED_out = 7'b1111111;
    end else begin
      case (digit)
        4'd0:    LED_out = 7'b0000001;
        4'd1:    LED_out = 7'b1001111;
        4'd2:    LED_out = 7'b0010010;
        4'd3:    LED_out = 7'b0000110;
        4'd4:    LED_out = 7'b1001100;
        4'd5:    LED_out = 7'b0100100;
        4'd6:    LED_out = 7'b0100000;
        4'd7:    LED_out = 7'b0001111;
        4'd8:    LED_out = 7'b0000000;
        4'd9:    LED_out = 7'b0000100;
        default: LED_out = 7'b1111111;
      endcase
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver: reset state, conversion timing, scan sequence, blanking, busy and abort.
module tb_ssd_scan_driver;

  logic       clk;
  logic       reset;
  logic [3:0] anode0, anode1;
  logic [6:0] led0, led1;
  logic [1:0] st0, st1;

  int checks = 0;
  int errors = 0;
  int edge_cnt;

  logic [3:0] anode_tab [4];
  logic [6:0] led_1234  [4];

  ssd_scan_driver_if #(.VALUE_W(13)) bus0 ();
  ssd_scan_driver_if #(.VALUE_W(13)) bus1 ();

  ssd_scan_driver #(.VALUE_W(13), .REFRESH_DIV(4), .BLANK_LZ(1)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave),
    .Anode(anode0), .LED_out(led0), .fsm_state(st0)
  );

  ssd_scan_driver #(.VALUE_W(13), .REFRESH_DIV(4), .BLANK_LZ(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave),
    .Anode(anode1), .LED_out(led1), .fsm_state(st1)
  );

  // Clock and reset-relative edge counter (expected scan index = edge_cnt[3:2] for REFRESH_DIV = 4).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int v, input logic vld);
    bus0.value_in = 13'(v);
    bus0.in_valid = vld;
    bus1.value_in = 13'(v);
    bus1.in_valid = vld;
  endtask

  // Present v for one edge, optionally inject a second request while busy, then check commit timing.
  task automatic send(input int v, input logic [15:0] exp, input int intr_at, input int intr_v);
    @(negedge clk);
    drive(v, 1'b1);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) drive(0, 1'b0);
      if (i == intr_at) drive(intr_v, 1'b1);
      if (i == intr_at + 1) drive(0, 1'b0);
      chk("busy_in_ready", 16'(bus0.in_ready), 16'd0);
      chk("busy_bcd_valid", 16'(bus0.bcd_valid), 16'd0);
    end
    @(negedge clk);
    chk("commit_bcd_valid", 16'(bus0.bcd_valid), 16'd1);
    chk("commit_in_ready", 16'(bus0.in_ready), 16'd1);
    chk("commit_bcd_out", bus0.bcd_out, exp);
    chk("commit_bcd_out_nblank", bus1.bcd_out, exp);
    @(negedge clk);
    chk("post_bcd_valid", 16'(bus0.bcd_valid), 16'd0);
    chk("post_in_ready", 16'(bus0.in_ready), 16'd1);
    chk("post_bcd_out", bus0.bcd_out, exp);
  endtask

  initial begin
    logic seen;
    int   k;

    anode_tab[0] = 4'b1110; anode_tab[1] = 4'b1101;
    anode_tab[2] = 4'b1011; anode_tab[3] = 4'b0111;
    led_1234[0]  = 7'b1001100; led_1234[1] = 7'b0000110;
    led_1234[2]  = 7'b0010010; led_1234[3] = 7'b1001111;

    // Reset state
    reset = 1'b0;
    drive(0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_anode", 16'(anode0), 16'b1110);
    chk("rst_led", 16'(led0), 16'b0000001);
    chk("rst_in_ready", 16'(bus0.in_ready), 16'd1);
    chk("rst_bcd_valid", 16'(bus0.bcd_valid), 16'd0);
    chk("rst_bcd_out", bus0.bcd_out, 16'h0000);
    chk("rst_state", 16'(st0), 16'd0);

    // Conversion of 1234 and its scan sequence
    send(1234, 16'h1234, -10, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      k = int'(edge_cnt[3:2]);
      chk("scan1234_anode", 16'(anode0), 16'(anode_tab[k]));
      chk("scan1234_led", 16'(led0), 16'(led_1234[k]));
    end

    // Busy: 555 presented three cycles into converting 42 is ignored
    send(42, 16'h0042, 3, 555);

    // Maximum value
    send(8191, 16'h8191, -10, 0);

    // Value 7: leading-zero blanking on dut0, zeros shown on dut1
    send(7, 16'h0007, -10, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      k = int'(edge_cnt[3:2]);
      chk("scan7_anode", 16'(anode0), 16'(anode_tab[k]));
      chk("scan7_anode_nblank", 16'(anode1), 16'(anode_tab[k]));
      if (k == 0) begin
        chk("scan7_led_ones", 16'(led0), 16'b0001111);
        chk("scan7_led_ones_nblank", 16'(led1), 16'b0001111);
      end else begin
        chk("scan7_led_blank", 16'(led0), 16'b1111111);
        chk("scan7_led_zero_nblank", 16'(led1), 16'b0000001);
      end
    end

    // Abort: reset in the middle of converting 999
    @(negedge clk);
    drive(999, 1'b1);
    @(negedge clk);
    drive(0, 1'b0);
    chk("abort_state_conv", 16'(st0), 16'd1);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_bcd_out", bus0.bcd_out, 16'h0000);
    chk("abort_in_ready", 16'(bus0.in_ready), 16'd1);
    chk("abort_bcd_valid", 16'(bus0.bcd_valid), 16'd0);
    chk("abort_state", 16'(st0), 16'd0);
    chk("abort_anode", 16'(anode0), 16'b1110);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.bcd_valid !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_pulse", 16'(seen), 16'd0);
    chk("abort_bcd_out_after", bus0.bcd_out, 16'h0000);
    chk("abort_in_ready_after", 16'(bus0.in_ready), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
